// File: rtl/ddr4_wr_burst_ctrl.sv
// Write-burst engine: drains a first-word-fall-through write-data FIFO into the MIG native
// user interface, issuing one write command per 512-bit beat at consecutive addresses.
module ddr4_wr_burst_ctrl #(
    parameter int unsigned ADDR_W    = 29,
    parameter int unsigned LEN_W     = 8,
    parameter int unsigned ADDR_STEP = 8
) (
    input  logic              ui_clk,
    input  logic              rst,
    input  logic              init_calib_complete,
    input  logic              wr_start,
    input  logic [ADDR_W-1:0] wr_base_addr,
    input  logic [LEN_W-1:0]  wr_burst_len,
    input  logic              fifo_empty,
    input  logic [511:0]      fifo_data,
    input  logic [63:0]       fifo_mask,
    output logic              data_req,
    output logic              app_en,
    output logic [2:0]        app_cmd,
    output logic [ADDR_W-1:0] app_addr,
    input  logic              app_rdy,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    output logic [511:0]      app_wdf_data,
    output logic [63:0]       app_wdf_mask,
    input  logic              app_wdf_rdy,
    output logic              busy,
    output logic              done
);

    // One extra bit keeps the compare exact at the maximum burst length.
    localparam int unsigned CW = LEN_W + 1;

    typedef enum logic [1:0] {
        StIdle,
        StBurst,
        StDone
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     len_q, len_d;
    logic [CW-1:0]     cmd_cnt_q, cmd_cnt_d;
    logic [CW-1:0]     dat_cnt_q, dat_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              in_burst;
    logic [CW-1:0]     lead;
    logic              cmd_acc;

    always_ff @(posedge ui_clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            len_q     <= '0;
            cmd_cnt_q <= '0;
            dat_cnt_q <= '0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cmd_cnt_q <= cmd_cnt_d;
            dat_cnt_q <= dat_cnt_d;
            addr_q    <= addr_d;
        end
    end

    // Outputs depend only on registered state and FIFO/ready inputs; app_en never sees app_rdy.
    always_comb begin
        in_burst     = (state_q == StBurst);
        lead         = dat_cnt_q - cmd_cnt_q;
        app_wdf_wren = in_burst && !fifo_empty && (dat_cnt_q < len_q) && (lead < CW'(2));
        data_req     = app_wdf_wren && app_wdf_rdy;
        app_en       = in_burst && (cmd_cnt_q < len_q) && (cmd_cnt_q < dat_cnt_q);
        cmd_acc      = app_en && app_rdy;
        app_cmd      = 3'b000;
        app_addr     = addr_q;
        app_wdf_end  = app_wdf_wren;
        app_wdf_data = fifo_data;
        app_wdf_mask = fifo_mask;
        busy         = in_burst;
        done         = (state_q == StDone);
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cmd_cnt_d = cmd_cnt_q;
        dat_cnt_d = dat_cnt_q;
        addr_d    = addr_q;
        unique case (state_q)
            StIdle: begin
                if (wr_start && init_calib_complete && (wr_burst_len != '0)) begin
                    state_d   = StBurst;
                    len_d     = {1'b0, wr_burst_len};
                    cmd_cnt_d = '0;
                    dat_cnt_d = '0;
                    addr_d    = wr_base_addr;
                end
            end
            StBurst: begin
                if (data_req) begin
                    dat_cnt_d = dat_cnt_q + CW'(1);
                end
                if (cmd_acc) begin
                    cmd_cnt_d = cmd_cnt_q + CW'(1);
                    addr_d    = addr_q + ADDR_W'(ADDR_STEP);
                end
                // Look at next-cycle counts so done follows the last command by one cycle.
                if ((dat_cnt_d == len_q) && (cmd_cnt_d == len_q)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_ddr4_wr_burst_ctrl.sv
// Bench for ddr4_wr_burst_ctrl: directed scenarios plus randomized bursts, checked each cycle
// against a transaction-level model of beats, commands and burst lifetime.
module tb_ddr4_wr_burst_ctrl;

    localparam int ADDR_W = 29;
    localparam int LEN_W  = 8;

    logic              ui_clk = 1'b0;
    logic              rst;
    logic              init_calib_complete;
    logic              wr_start;
    logic [ADDR_W-1:0] wr_base_addr;
    logic [LEN_W-1:0]  wr_burst_len;
    logic              fifo_empty;
    logic [511:0]      fifo_data;
    logic [63:0]       fifo_mask;
    logic              data_req;
    logic              app_en;
    logic [2:0]        app_cmd;
    logic [ADDR_W-1:0] app_addr;
    logic              app_rdy;
    logic              app_wdf_wren;
    logic              app_wdf_end;
    logic [511:0]      app_wdf_data;
    logic [63:0]       app_wdf_mask;
    logic              app_wdf_rdy;
    logic              busy;
    logic              done;

    ddr4_wr_burst_ctrl dut (
        .ui_clk              (ui_clk),
        .rst                 (rst),
        .init_calib_complete (init_calib_complete),
        .wr_start            (wr_start),
        .wr_base_addr        (wr_base_addr),
        .wr_burst_len        (wr_burst_len),
        .fifo_empty          (fifo_empty),
        .fifo_data           (fifo_data),
        .fifo_mask           (fifo_mask),
        .data_req            (data_req),
        .app_en              (app_en),
        .app_cmd             (app_cmd),
        .app_addr            (app_addr),
        .app_rdy             (app_rdy),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_rdy         (app_wdf_rdy),
        .busy                (busy),
        .done                (done)
    );

    always #5 ui_clk = ~ui_clk;

    typedef struct packed {
        logic [63:0]  m;
        logic [511:0] d;
    } beat_t;

    beat_t             fq[$];
    logic [ADDR_W-1:0] acc_addr[$];
    int                n_checks = 0;
    int                n_errors = 0;

    // Transaction-level model of the burst in flight.
    bit                m_active = 0;
    bit                m_done   = 0;
    int                m_len    = 0;
    int                m_dat    = 0;
    int                m_cmd    = 0;
    logic [ADDR_W-1:0] m_base   = '0;

    int                cyc      = 0;
    int                done_cyc = -1;
    int                obs_pops = 0;
    bit                rnd_mode = 0;
    bit                acc_d    = 0;
    bit                prev_en  = 0;
    bit                prev_rdy = 0;
    logic [ADDR_W-1:0] prev_addr = '0;

    task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t rand_beat();
        beat_t b;
        for (int i = 0; i < 16; i++) b.d[i*32 +: 32] = $urandom();
        b.m = {$urandom(), $urandom()};
        return b;
    endfunction

    task automatic refresh();
        fifo_empty = (fq.size() == 0);
        if (fq.size() != 0) begin
            fifo_data = fq[0].d;
            fifo_mask = fq[0].m;
        end
    endtask

    task automatic push(input int n);
        for (int i = 0; i < n; i++) fq.push_back(rand_beat());
        refresh();
    endtask

    task automatic monitor();
        bit                exp_wren;
        bit                exp_en;
        bit                acc_c;
        logic [ADDR_W-1:0] ea;
        exp_wren = m_active && !fifo_empty && (m_dat < m_len) && ((m_dat - m_cmd) < 2);
        exp_en   = m_active && (m_cmd < m_len) && (m_cmd < m_dat);
        ea       = m_base + ADDR_W'(m_cmd) * ADDR_W'(8);
        chk("busy", busy, m_active);
        chk("done", done, m_done);
        chk("wdf_wren", app_wdf_wren, exp_wren);
        chk("wdf_end", app_wdf_end, exp_wren);
        chk("data_req", data_req, exp_wren && app_wdf_rdy);
        chk("app_en", app_en, exp_en);
        chk("app_cmd", app_cmd, 3'b000);
        if (exp_wren) begin
            chk("wdf_data", app_wdf_data, fq[0].d);
            chk("wdf_mask", app_wdf_mask, fq[0].m);
        end
        if (exp_en) chk("app_addr", app_addr, ea);
        if (prev_en && !prev_rdy) chk("cmd_hold", {app_en, app_addr}, {1'b1, prev_addr});
        if (data_req === 1'b1) obs_pops++;
        if (done === 1'b1) done_cyc = cyc + 1;
        acc_d = exp_wren && app_wdf_rdy;
        acc_c = exp_en && app_rdy;
        if (acc_c) acc_addr.push_back(ea);
        prev_en   = exp_en;
        prev_rdy  = app_rdy;
        prev_addr = ea;
        if (m_done) begin
            m_done = 0;
        end else if (m_active) begin
            m_dat += int'(acc_d);
            m_cmd += int'(acc_c);
            if (m_dat == m_len && m_cmd == m_len) begin
                m_active = 0;
                m_done   = 1;
            end
        end else if (wr_start && init_calib_complete && wr_burst_len != 0 && !rst) begin
            m_active = 1;
            m_len    = int'(wr_burst_len);
            m_dat    = 0;
            m_cmd    = 0;
            m_base   = wr_base_addr;
        end
    endtask

    task automatic cycle();
        @(negedge ui_clk);
        monitor();
        @(posedge ui_clk);
        cyc++;
        #1;
        if (acc_d) void'(fq.pop_front());
        acc_d    = 0;
        wr_start = 1'b0;
        if (rnd_mode) begin
            app_rdy     = ($urandom % 4) != 0;
            app_wdf_rdy = ($urandom % 4) != 0;
            if (($urandom % 2) == 1 && fq.size() < 6) fq.push_back(rand_beat());
        end
        refresh();
    endtask

    task automatic start(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len);
        wr_base_addr = base;
        wr_burst_len = len;
        wr_start     = 1'b1;
        cycle();
    endtask

    task automatic wait_idle(input int limit, input string tag);
        int n = 0;
        while ((m_active || m_done) && n < limit) begin
            cycle();
            n++;
        end
        chk({tag, "_timeout"}, m_active || m_done, 1'b0);
    endtask

    task automatic outputs_zero(input string tag);
        chk({tag, "_out0"}, {app_en, app_wdf_wren, app_wdf_end, data_req, busy, done, app_cmd},
            '0);
        chk({tag, "_addr0"}, app_addr, '0);
    endtask

    initial begin
        int t;
        logic [ADDR_W-1:0] wrap_exp [4];
        wrap_exp = '{29'h1FFFFFF0, 29'h1FFFFFF8, 29'h0, 29'h8};

        rst                 = 1'b1;
        init_calib_complete = 1'b1;
        wr_start            = 1'b0;
        wr_base_addr        = '0;
        wr_burst_len        = '0;
        app_rdy             = 1'b1;
        app_wdf_rdy         = 1'b1;
        fifo_data           = '0;
        fifo_mask           = '0;
        refresh();

        // Reset state, FIFO pass-through while idle.
        #12;
        push(4);
        #1;
        outputs_zero("reset");
        chk("reset_pass_data", app_wdf_data, fq[0].d);
        chk("reset_pass_mask", app_wdf_mask, fq[0].m);
        @(posedge ui_clk);
        #1;
        rst = 1'b0;

        // Best case: base 0x100, len 4, pre-filled FIFO, both readies high.
        acc_addr.delete();
        obs_pops = 0;
        start(29'h100, 8'd4);
        t = cyc;
        wait_idle(50, "t1");
        chk("t1_done_latency", done_cyc - t, 6);
        chk("t1_pops", obs_pops, 4);
        chk("t1_ncmd", acc_addr.size(), 4);
        for (int i = 0; i < acc_addr.size() && i < 4; i++)
            chk("t1_cmd_addr", acc_addr[i], ADDR_W'(32'h100 + i * 8));

        // Command stall on the second command.
        push(4);
        obs_pops = 0;
        start(29'h400, 8'd4);
        for (int n = 0; n < 20 && m_cmd < 1; n++) cycle();
        app_rdy = 1'b0;
        repeat (5) cycle();
        chk("t2_stall_pops", obs_pops, 3);
        app_rdy = 1'b1;
        wait_idle(50, "t2");
        chk("t2_pops", obs_pops, 4);

        // FIFO runs dry mid-burst for 3 cycles.
        push(4);
        obs_pops = 0;
        start(29'h800, 8'd8);
        for (int n = 0; n < 30 && m_dat < 4; n++) cycle();
        repeat (3) cycle();
        chk("t3_gap_pops", obs_pops, 4);
        push(4);
        wait_idle(60, "t3");
        chk("t3_pops", obs_pops, 8);

        // Ignored starts: during a burst, without calibration, with zero length.
        push(4);
        obs_pops = 0;
        start(29'hA00, 8'd4);
        start(29'h0, 8'd4);
        wait_idle(50, "t4");
        chk("t4_pops", obs_pops, 4);
        chk("t4_fifo_left", fq.size(), 0);
        push(2);
        obs_pops = 0;
        done_cyc = -1;
        init_calib_complete = 1'b0;
        start(29'hC00, 8'd2);
        repeat (3) cycle();
        chk("t4_nocal_busy", busy, 1'b0);
        init_calib_complete = 1'b1;
        start(29'hC00, 8'd0);
        repeat (3) cycle();
        chk("t4_ignored_pops", obs_pops, 0);
        chk("t4_no_done", done_cyc, -1);

        // Address wrap at the top of the address space.
        push(2);
        acc_addr.delete();
        start(29'h1FFFFFF0, 8'd4);
        wait_idle(50, "t5");
        chk("t5_ncmd", acc_addr.size(), 4);
        for (int i = 0; i < acc_addr.size() && i < 4; i++) chk("t5_wrap_addr", acc_addr[i],
                                                                 wrap_exp[i]);

        // Asynchronous reset after two of six beats.
        push(6);
        obs_pops = 0;
        done_cyc = -1;
        start(29'h1000, 8'd6);
        for (int n = 0; n < 30 && obs_pops < 2; n++) cycle();
        #2;
        rst = 1'b1;
        #1;
        outputs_zero("t6_rst");
        m_active = 0;
        m_done   = 0;
        prev_en  = 0;
        cycle();
        cycle();
        rst = 1'b0;
        chk("t6_no_done", done_cyc, -1);
        chk("t6_fifo_left", fq.size(), 4);
        acc_addr.delete();
        obs_pops = 0;
        start(29'h2000, 8'd4);
        wait_idle(50, "t6");
        chk("t6_fresh_addr", acc_addr.size() > 0 ? acc_addr[0] : 29'h1FFFFFFF, 29'h2000);
        chk("t6_pops", obs_pops, 4);

        // Randomized bursts with random ready and FIFO fill, then a maximum-length burst.
        rnd_mode = 1;
        for (int k = 0; k < 15; k++) begin
            obs_pops = 0;
            start(ADDR_W'($urandom()), 8'($urandom_range(1, 12)));
            wait_idle(1000, "rnd");
            chk("rnd_pops", obs_pops, m_len);
            repeat ($urandom_range(0, 3)) cycle();
        end
        obs_pops = 0;
        start(29'h3000, 8'd255);
        wait_idle(4000, "max");
        chk("max_pops", obs_pops, 255);
        rnd_mode = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
